// File: rtl/table_fsm_pkg.sv
// Shared widths, constants and rule record for the table-programmed Mealy controller.
// The widths here are the instance widths of the controller built from this slice.
package table_fsm_pkg;
    localparam int NI      = 16;
    localparam int NO      = 17;
    localparam int NS      = 11;
    localparam int NR      = 8;
    localparam int SW      = $clog2(NS);
    localparam int RW      = $clog2(NR);
    localparam int DWELL_W = 16;

    localparam logic [SW-1:0] RST_ST = '0;

    typedef struct packed {
        logic          vld;
        logic [NI-1:0] mask;
        logic [NI-1:0] val;
        logic [SW-1:0] next;
        logic [NO-1:0] out;
    } rule_t;

    function automatic logic legal_st(input logic [SW-1:0] s);
        return s < SW'(NS);
    endfunction
endpackage

// File: rtl/table_fsm_rule_match.sv
// NR-way parallel masked compare of x against one state's rules; lowest index wins.
// Purely combinational, zero latency.
module table_fsm_rule_match
    import table_fsm_pkg::*;
(
    input  rule_t [NR-1:0] row,
    input  logic  [NI-1:0] x,
    output logic           hit,
    output logic  [SW-1:0] next,
    output logic  [NO-1:0] out
);
    always_comb begin
        hit  = 1'b0;
        next = '0;
        out  = '0;
        // Scan from the top so the lowest firing index is the last to overwrite.
        for (int r = NR - 1; r >= 0; r--) begin
            if (row[r].vld && ((x & row[r].mask) == (row[r].val & row[r].mask))) begin
                hit  = 1'b1;
                next = row[r].next;
                out  = row[r].out;
            end
        end
    end
endmodule

// File: rtl/table_fsm_ctrl.sv
// Table-programmed Mealy controller: rule table, falling-edge state register, dwell watchdog, write lock.
// y is combinational from state/x/table; state, counters and table update on the falling clock edge.
module table_fsm_ctrl
    import table_fsm_pkg::*;
#(
    parameter int DWELL_MAX = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [NI-1:0] x,
    output logic [NO-1:0] y,
    output logic [SW-1:0] state,
    input  logic          cfg_we,
    input  logic [SW-1:0] cfg_st,
    input  logic [RW-1:0] cfg_idx,
    input  logic [NI-1:0] cfg_mask,
    input  logic [NI-1:0] cfg_val,
    input  logic [SW-1:0] cfg_next,
    input  logic [NO-1:0] cfg_out,
    input  logic          cfg_vld,
    input  logic          cfg_lock,
    output logic          locked,
    output logic          wd_trip,
    output logic [7:0]    trip_cnt
);
    rule_t [NR-1:0]   tbl   [NS];
    logic  [NR-1:0]   vld_q [NS];
    rule_t [NR-1:0]   row;
    logic             hit;
    logic  [SW-1:0]   hit_next;
    logic  [NO-1:0]   hit_out;
    logic  [DWELL_W-1:0] dwell, dwell_d;
    logic  [SW-1:0]   state_d, target;
    logic  [7:0]      trip_d;
    logic             wr_en;

    assign wr_en = cfg_we && !en && !locked && legal_st(cfg_st);

    // Rule payload needs no reset: an entry is inert until its valid bit is set.
    always_ff @(negedge clk) begin
        if (wr_en) begin
            tbl[cfg_st][cfg_idx] <= '{vld: cfg_vld, mask: cfg_mask, val: cfg_val,
                                      next: cfg_next, out: cfg_out};
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NS; s++) vld_q[s] <= '0;
        end else if (wr_en) begin
            vld_q[cfg_st][cfg_idx] <= cfg_vld;
        end
    end

    always_comb begin
        row = '0;
        if (legal_st(state)) begin
            row = tbl[state];
            for (int r = 0; r < NR; r++) row[r].vld = vld_q[state][r];
        end
    end

    table_fsm_rule_match u_match (
        .row  (row),
        .x    (x),
        .hit  (hit),
        .next (hit_next),
        .out  (hit_out)
    );

    always_comb begin
        target = state;
        if (!legal_st(state))   target = RST_ST;
        else if (hit)           target = legal_st(hit_next) ? hit_next : RST_ST;

        // A trip can only happen on a hold, so a real transition always wins.
        wd_trip = en && (target == state) && (dwell == DWELL_W'(DWELL_MAX));

        state_d = state;
        dwell_d = dwell;
        trip_d  = trip_cnt;
        if (en) begin
            if (target != state) begin
                state_d = target;
                dwell_d = '0;
            end else if (wd_trip) begin
                state_d = RST_ST;
                dwell_d = '0;
                if (trip_cnt != 8'hFF) trip_d = trip_cnt + 8'd1;
            end else begin
                dwell_d = dwell + 1'b1;
            end
        end

        y = (en && hit) ? hit_out : '0;
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RST_ST;
            dwell    <= '0;
            trip_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            state    <= state_d;
            dwell    <= dwell_d;
            trip_cnt <= trip_d;
            locked   <= locked | cfg_lock;
        end
    end
endmodule

// File: tb/tb_table_fsm_ctrl.sv
// Randomized and directed checks of table_fsm_ctrl against a rule-list reference model.
module tb_table_fsm_ctrl;
    import table_fsm_pkg::*;

    localparam int DMAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [NI-1:0] x = '0;
    logic [NO-1:0] y;
    logic [SW-1:0] state;
    logic          cfg_we = 1'b0;
    logic [SW-1:0] cfg_st = '0;
    logic [RW-1:0] cfg_idx = '0;
    logic [NI-1:0] cfg_mask = '0;
    logic [NI-1:0] cfg_val = '0;
    logic [SW-1:0] cfg_next = '0;
    logic [NO-1:0] cfg_out = '0;
    logic          cfg_vld = 1'b0;
    logic          cfg_lock = 1'b0;
    logic          locked;
    logic          wd_trip;
    logic [7:0]    trip_cnt;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: per-state rule lists plus plain integer bookkeeping.
    bit            m_vld  [NS][NR];
    logic [NI-1:0] m_mask [NS][NR];
    logic [NI-1:0] m_val  [NS][NR];
    int            m_next [NS][NR];
    logic [NO-1:0] m_out  [NS][NR];
    int            m_state, m_dwell, m_trips;
    bit            m_locked;

    always #5 clk = ~clk;

    table_fsm_ctrl #(.DWELL_MAX(DMAX)) dut (
        .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .state(state),
        .cfg_we(cfg_we), .cfg_st(cfg_st), .cfg_idx(cfg_idx), .cfg_mask(cfg_mask),
        .cfg_val(cfg_val), .cfg_next(cfg_next), .cfg_out(cfg_out), .cfg_vld(cfg_vld),
        .cfg_lock(cfg_lock), .locked(locked), .wd_trip(wd_trip), .trip_cnt(trip_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++)
            for (int r = 0; r < NR; r++) m_vld[s][r] = 1'b0;
        m_state = 0; m_dwell = 0; m_trips = 0; m_locked = 1'b0;
    endtask

    // First matching rule of the current state, if the state is a legal one.
    function automatic void model_match(output bit hit, output int nxt, output logic [NO-1:0] o);
        hit = 1'b0; nxt = m_state; o = '0;
        if (m_state < NS) begin
            for (int r = 0; r < NR; r++) begin
                if (m_vld[m_state][r] && ((x & m_mask[m_state][r]) == (m_val[m_state][r] & m_mask[m_state][r]))) begin
                    hit = 1'b1; nxt = m_next[m_state][r]; o = m_out[m_state][r];
                    break;
                end
            end
        end
    endfunction

    // One falling edge: check outputs mid-high phase, then advance the model.
    task automatic tick();
        bit hit;
        int nxt, tgt;
        logic [NO-1:0] o;
        bit exp_trip;
        @(posedge clk); #1;
        model_match(hit, nxt, o);
        if (m_state >= NS)  tgt = 0;
        else if (hit)       tgt = (nxt >= NS) ? 0 : nxt;
        else                tgt = m_state;
        exp_trip = en && (tgt == m_state) && (m_dwell == DMAX);
        check("y", y, (en && hit) ? o : '0);
        check("state", state, m_state);
        check("wd_trip", wd_trip, exp_trip);
        check("trip_cnt", trip_cnt, m_trips);
        check("locked", locked, m_locked);
        if (cfg_we && !en && !m_locked && int'(cfg_st) < NS) begin
            m_vld[cfg_st][cfg_idx]  = cfg_vld;
            m_mask[cfg_st][cfg_idx] = cfg_mask;
            m_val[cfg_st][cfg_idx]  = cfg_val;
            m_next[cfg_st][cfg_idx] = int'(cfg_next);
            m_out[cfg_st][cfg_idx]  = cfg_out;
        end
        if (cfg_lock) m_locked = 1'b1;
        if (en) begin
            if (tgt != m_state) begin
                m_state = tgt; m_dwell = 0;
            end else if (exp_trip) begin
                m_state = 0; m_dwell = 0;
                if (m_trips < 255) m_trips++;
            end else begin
                m_dwell++;
            end
        end
        @(negedge clk); #1;
    endtask

    task automatic wr(input int s, input int r, input logic [NI-1:0] mk, input logic [NI-1:0] vl,
                      input int nx, input logic [NO-1:0] o, input bit v, input bit lk);
        en = 1'b0; cfg_we = 1'b1; cfg_lock = lk;
        cfg_st = SW'(s); cfg_idx = RW'(r); cfg_mask = mk; cfg_val = vl;
        cfg_next = SW'(nx); cfg_out = o; cfg_vld = v;
        tick();
        cfg_we = 1'b0; cfg_lock = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [NO-1:0] exp);
        #1 check(tag, y, exp);
    endtask

    // Async reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_state", state, 0);
        check("rst_y", y, 0);
        check("rst_locked", locked, 0);
        check("rst_trip_cnt", trip_cnt, 0);
        #1 rst = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk); #1;

        // 1: empty table, state holds at reset state without tripping early
        do_reset();
        en = 1'b1;
        for (int i = 0; i < DMAX - 1; i++) begin
            x = NI'($urandom);
            tick();
        end
        check("t1_no_trip", trip_cnt, 0);

        // 2: single rule, zero-latency output, transition on next edge
        wr(0, 0, 16'h0040, 16'h0040, 1, 17'h00141, 1'b1, 1'b0);
        en = 1'b1; x = 16'h0040;
        peek("t2_y", 17'h00141);
        tick();
        check("t2_state", state, 1);

        // 3: priority between overlapping rules
        en = 1'b0; tick();
        do_reset();
        wr(0, 0, 16'h000F, 16'h0003, 2, 17'h11111, 1'b1, 1'b0);
        wr(0, 3, 16'h0003, 16'h0003, 5, 17'h0AAAA, 1'b1, 1'b0);
        en = 1'b1; x = 16'h0003;
        peek("t3_r0_wins", 17'h11111);
        wr(0, 0, 16'h000F, 16'h0003, 2, 17'h11111, 1'b0, 1'b0);
        en = 1'b1; x = 16'h0003;
        peek("t3_r3_wins", 17'h0AAAA);
        tick();
        check("t3_state", state, 5);

        // 4: watchdog trips on the fifth held edge; trip counter saturates
        en = 1'b0; tick();
        do_reset();
        wr(0, 0, 16'h0000, 16'h0000, 2, 17'h00001, 1'b1, 1'b0);
        en = 1'b1;
        tick();
        check("t4_in_s2", state, 2);
        for (int i = 0; i < DMAX; i++) begin
            x = NI'($urandom);
            tick();
        end
        peek("t4_y_trip", 17'h0);
        check("t4_wd_trip", wd_trip, 1);
        tick();
        check("t4_state", state, 0);
        check("t4_trip1", trip_cnt, 1);
        for (int k = 0; k < 299; k++)
            for (int i = 0; i < DMAX + 2; i++) tick();
        check("t4_trip_sat", trip_cnt, 255);

        // 5: write-then-lock on one edge, later write ignored, reset clears
        en = 1'b0; tick();
        do_reset();
        wr(0, 2, 16'hFFFF, 16'h1234, 3, 17'h02222, 1'b1, 1'b1);
        wr(0, 1, 16'hFFFF, 16'h5678, 4, 17'h03333, 1'b1, 1'b0);
        check("t5_locked", locked, 1);
        en = 1'b1; x = 16'h1234;
        peek("t5_first_present", 17'h02222);
        x = 16'h5678;
        peek("t5_second_absent", 17'h0);
        en = 1'b0; tick();
        do_reset();
        en = 1'b1; x = 16'h1234;
        peek("t5_table_empty", 17'h0);

        // 6: write while enabled ignored; async reset mid-cycle
        en = 1'b0; tick();
        do_reset();
        en = 1'b1; cfg_we = 1'b1; cfg_st = '0; cfg_idx = '0; cfg_mask = '0; cfg_val = '0;
        cfg_next = SW'(6); cfg_out = 17'h5; cfg_vld = 1'b1;
        tick();
        cfg_we = 1'b0;
        peek("t6_we_en_ignored", 17'h0);
        wr(0, 0, 16'h0000, 16'h0000, 6, 17'h00005, 1'b1, 1'b0);
        en = 1'b1;
        peek("t6_y", 17'h00005);
        tick();
        check("t6_state6", state, 6);
        do_reset();

        // Random programming and running, including illegal next states and out-of-range writes
        en = 1'b0; tick();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(3) == 0) begin
                en = 1'b0;
                cfg_we = 1'($urandom_range(1));
                cfg_lock = ($urandom_range(599) == 0);
            end else begin
                en = 1'b1;
                cfg_we = ($urandom_range(7) == 0);
                cfg_lock = 1'b0;
            end
            cfg_st   = SW'($urandom_range(12));
            cfg_idx  = RW'($urandom);
            cfg_mask = NI'($urandom & $urandom & $urandom);
            cfg_val  = NI'($urandom);
            cfg_next = SW'($urandom);
            cfg_out  = NO'($urandom);
            cfg_vld  = ($urandom_range(4) != 0);
            x        = NI'($urandom);
            tick();
        end
        cfg_we = 1'b0; cfg_lock = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
